mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the Mini SRC datapath bus.
- Accepts the level-sensitive Read/Write requests the control sequencer raises against MAR/MDR.
- Performs the access on an internal word RAM after a programmable number of wait states.
- Returns data plus a MemReady completion flag and follows a four-phase request/ready handshake, so a request held over several T-states produces exactly one access.

Parameters:
- ADDR_WIDTH, 9, width of Address (MAR low bits).
- DATA_WIDTH, 32, word width.
- DEPTH, 512, number of RAM words; must not exceed 2**ADDR_WIDTH.
- WAIT_STATES, 0, extra cycles between request accept and access, range 0..15.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Clear_n  in  1  asynchronous active-low reset.
- Read  in  1  read request, level, from the control unit.
- Write  in  1  write request, level, from the control unit.
- Address  in  ADDR_WIDTH  word address, from the MAR output.
- DataIn  in  DATA_WIDTH  store data, from the MDR output.
- Mdatain  out  DATA_WIDTH  registered read data, to the MDR input mux.
- MemReady  out  1  access complete; high for the whole RESP state.
- Busy  out  1  high in the WAIT and RESP states.

Behaviour:
Reset (Clear_n low, asynchronous):
- State goes to IDLE.
- Mdatain = 0, MemReady = 0, Busy = 0, wait counter = 0, latched op/address/data = 0.
- RAM contents are not cleared.
- Reset mid-operation aborts the request; a write not yet committed is dropped.

State machine (IDLE, WAIT, RESP, HOLD):
- IDLE: on an edge with Read or Write high, latch op, Address and DataIn.
  - If WAIT_STATES = 0, go to RESP and perform the access on the same edge.
  - Otherwise go to WAIT and load the counter with WAIT_STATES-1.
- WAIT: decrement the counter each edge. When the counter is 0, perform the access and go to RESP.
- Access: the write commits DataIn_latched to RAM[addr_latched]; a read loads Mdatain <= RAM[addr_latched].
- Latency: MemReady rises WAIT_STATES+1 edges after the accept edge.
- RESP: MemReady = 1 for one cycle, then go to HOLD.
- HOLD: wait until Read = 0 and Write = 0, then go to IDLE. No new access is started while a request stays asserted.
- Mdatain holds its last read value until the next read access; writes leave Mdatain unchanged.

Boundary rules:
- Read and Write both high at accept: treated as Write; Read is ignored.
- Address >= DEPTH: a read returns 0; a write is discarded. MemReady is still given.
- Changes on Address/DataIn/Read/Write after accept have no effect until the next IDLE accept.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- Busy and MemReady are registered (no combinational path from inputs).

Optional Feature:
- Macro MEM_RESPONDER_ERR_EN.
- When defined, an extra output ReqError (1 bit) is added. It is sticky and set at accept on:
  - Read & Write both high, or
  - Address >= DEPTH.
- ReqError is cleared only by Clear_n. Access behaviour is identical to the macro-undefined case.
- When undefined, the port and its logic are absent.

Test Plan:
1. WAIT_STATES=0: Write=1, Address=9'h010, DataIn=32'hDEADBEEF for 2 cycles, then drop; Read=1 at 9'h010 -> MemReady high the cycle after accept; Mdatain=32'hDEADBEEF; exactly one write committed.
2. WAIT_STATES=3: Read at 9'h010 held 8 cycles -> MemReady high exactly 4 edges after accept for 1 cycle; Busy high 4 cycles; no second access until Read drops.
3. Read and Write both high, Address=9'h020, DataIn=32'h12345678 -> RAM[0x20]=32'h12345678; Mdatain unchanged; with MEM_RESPONDER_ERR_EN, ReqError=1 and stays 1.
4. DEPTH=256, Read at 9'h1FF -> Mdatain=0, MemReady asserted; Write at 9'h1FF -> no RAM word changes.
5. WAIT_STATES=5: Write 32'hCAFEF00D to 9'h005, pulse Clear_n low during WAIT -> outputs 0 immediately; RAM[5] keeps its old value; the next read of 9'h005 confirms it.
6. Back-to-back: Write 32'h1 @9'h0, release, Write 32'h2 @9'h1, release, Read @9'h0 then @9'h1 -> Mdatain 32'h1 then 32'h2; IDLE entered between each transaction.

Source files
------------

// File: rtl/mem_responder.sv
// Word-RAM responder for Read/Write requests held as levels; optional ReqError via MEM_RESPONDER_ERR_EN.
// Latency: MemReady rises WAIT_STATES+1 edges after the accept edge and stays high for one cycle.
// Backpressure: Busy is high during WAIT and RESP; a held request is not re-accepted until Read and Write both drop.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Clock,
  input  logic                  Clear_n,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  MemReady,
  output logic                  Busy
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic                  ReqError
`endif
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t                  state_q, state_nx;
  logic [3:0]              cnt_q, cnt_nx;
  logic                    op_wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    latch;
  logic                    do_access;
  logic                    acc_wr;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    acc_in_range;
  logic [IDX_W-1:0]        acc_idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // With zero wait states the access happens on the accept edge, so it must use the live inputs.
  always_comb begin
    acc_wr       = (state_q == S_IDLE) ? Write   : op_wr_q;
    acc_addr     = (state_q == S_IDLE) ? Address : addr_q;
    acc_data     = (state_q == S_IDLE) ? DataIn  : data_q;
    acc_in_range = ({1'b0, acc_addr} < DEPTH_W);
    acc_idx      = acc_addr[IDX_W-1:0];
  end

  // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP, HOLD until request released.
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    latch     = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_nx  = S_RESP;
          end else begin
            cnt_nx   = WS_LOAD;
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_nx  = S_RESP;
        end else begin
          cnt_nx = cnt_q - 4'd1;
        end
      end
      S_RESP: state_nx = S_HOLD;
      S_HOLD: begin
        if (!Read && !Write) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, counter, request latches and registered status flags.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      MemReady <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      if (latch) begin
        op_wr_q <= Write;
        addr_q  <= Address;
        data_q  <= DataIn;
      end
      MemReady <= (state_nx == S_RESP);
      Busy     <= (state_nx == S_WAIT) || (state_nx == S_RESP);
    end
  end

  // Read data register: only read accesses update it; out-of-range reads return zero.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      Mdatain <= '0;
    end else if (do_access && !acc_wr) begin
      Mdatain <= acc_in_range ? mem[acc_idx] : '0;
    end
  end

  // RAM array keeps its contents across reset; out-of-range writes are dropped.
  always_ff @(posedge Clock) begin
    if (do_access && acc_wr && acc_in_range) begin
      mem[acc_idx] <= acc_data;
    end
  end

`ifdef MEM_RESPONDER_ERR_EN
  // Sticky flag for conflicting or out-of-range requests, sampled at accept.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      ReqError <= 1'b0;
    end else if (latch && ((Read && Write) || !acc_in_range)) begin
      ReqError <= 1'b1;
    end
  end
`endif

endmodule
